// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_ctrl
// Purpose  : ID-stage operand bypass and hazard detection over FWD_STAGES
//            in-flight stages. Also tracks the mul/div busy window for HI/LO
//            consumers and keeps a saturating stall-cycle counter.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module hazard_forward_ctrl #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 3,
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REG_AW-1:0]              id_rs,
  input  logic [REG_AW-1:0]              id_rt,
  input  logic                           id_rs_used,
  input  logic                           id_rt_used,
  input  logic                           id_hilo,
  input  logic [DATA_W-1:0]              rs,
  input  logic [DATA_W-1:0]              rt,
  input  logic [FWD_STAGES*REG_AW-1:0]   stage_dst,
  input  logic [FWD_STAGES-1:0]          stage_wen,
  input  logic [FWD_STAGES-1:0]          stage_ready,
  input  logic [FWD_STAGES*DATA_W-1:0]   stage_data,
  input  logic                           muldiv_start,
  input  logic                           stall_cnt_clr,
  output logic                           if_stall,
  output logic                           id_stall,
  output logic                           ex_flush,
  output logic [DATA_W-1:0]              rfRs_forwarding,
  output logic [DATA_W-1:0]              rfRt_forwarding,
  output logic [1:0]                     hz_cause,
  output logic                           muldiv_busy,
  output logic [CNT_W-1:0]               stall_cnt
);

  localparam int MB_W = $clog2(MULDIV_LAT + 1);

  // Per-stage views of the packed stage buses.
  logic [DATA_W-1:0]     st_data [FWD_STAGES];
  logic [FWD_STAGES-1:0] match_rs;
  logic [FWD_STAGES-1:0] match_rt;

  // Register index 0 never matches, so it always takes the register file value.
  logic rs_nonzero;
  logic rt_nonzero;
  assign rs_nonzero = (id_rs != '0);
  assign rt_nonzero = (id_rt != '0);

  genvar g;
  generate
    for (g = 0; g < FWD_STAGES; g++) begin : g_stage
      logic [REG_AW-1:0] dst;
      assign dst        = stage_dst[g*REG_AW +: REG_AW];
      assign st_data[g] = stage_data[g*DATA_W +: DATA_W];
      assign match_rs[g] = stage_wen[g] && (dst == id_rs) && rs_nonzero;
      assign match_rt[g] = stage_wen[g] && (dst == id_rt) && rt_nonzero;
    end
  endgenerate

  // Priority select: walk oldest to youngest so the youngest (lowest index)
  // matching stage is the last to write and therefore wins. Its ready flag is
  // the only one that matters; an older ready copy is stale.
  logic rs_hit, rs_rdy;
  logic rt_hit, rt_rdy;
  always_comb begin
    rs_hit          = 1'b0;
    rs_rdy          = 1'b1;
    rfRs_forwarding = rs;
    rt_hit          = 1'b0;
    rt_rdy          = 1'b1;
    rfRt_forwarding = rt;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (match_rs[i]) begin
        rs_hit          = 1'b1;
        rs_rdy          = stage_ready[i];
        rfRs_forwarding = st_data[i];
      end
      if (match_rt[i]) begin
        rt_hit          = 1'b1;
        rt_rdy          = stage_ready[i];
        rfRt_forwarding = st_data[i];
      end
    end
  end

  // Busy window counter for the sequential multiply/divide unit.
  logic [MB_W-1:0] mb_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      mb_cnt <= '0;
    end else if (mb_cnt == '0) begin
      if (muldiv_start) begin
        mb_cnt <= MB_W'(MULDIV_LAT);
      end
    end else begin
      mb_cnt <= mb_cnt - MB_W'(1);
    end
  end

  assign muldiv_busy = (mb_cnt != '0);

  // Hazard classification; data and busy hazards merge into one stall.
  logic data_hz;
  logic busy_hz;
  assign data_hz  = (id_rs_used && rs_hit && !rs_rdy) ||
                    (id_rt_used && rt_hit && !rt_rdy);
  assign busy_hz  = id_hilo && muldiv_busy;
  assign hz_cause = {busy_hz, data_hz};
  assign id_stall = data_hz || busy_hz;
  assign if_stall = id_stall;
  assign ex_flush = id_stall;

  // Saturating stall-cycle counter; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst || stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (id_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forward_ctrl
// Purpose  : Directed self-checking bench for hazard_forward_ctrl with
//            MULDIV_LAT=4 and CNT_W=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;

  localparam int DATA_W     = 32;
  localparam int REG_AW     = 5;
  localparam int FWD_STAGES = 3;
  localparam int MULDIV_LAT = 4;
  localparam int CNT_W      = 4;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [REG_AW-1:0]            id_rs, id_rt;
  logic                         id_rs_used, id_rt_used, id_hilo;
  logic [DATA_W-1:0]            rs, rt;
  logic [FWD_STAGES*REG_AW-1:0] stage_dst;
  logic [FWD_STAGES-1:0]        stage_wen, stage_ready;
  logic [FWD_STAGES*DATA_W-1:0] stage_data;
  logic                         muldiv_start, stall_cnt_clr;
  logic                         if_stall, id_stall, ex_flush;
  logic [DATA_W-1:0]            rfRs_forwarding, rfRt_forwarding;
  logic [1:0]                   hz_cause;
  logic                         muldiv_busy;
  logic [CNT_W-1:0]             stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_forward_ctrl #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES),
    .MULDIV_LAT(MULDIV_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_hilo(id_hilo),
    .rs(rs), .rt(rt),
    .stage_dst(stage_dst), .stage_wen(stage_wen),
    .stage_ready(stage_ready), .stage_data(stage_data),
    .muldiv_start(muldiv_start), .stall_cnt_clr(stall_cnt_clr),
    .if_stall(if_stall), .id_stall(id_stall), .ex_flush(ex_flush),
    .rfRs_forwarding(rfRs_forwarding), .rfRt_forwarding(rfRt_forwarding),
    .hz_cause(hz_cause), .muldiv_busy(muldiv_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_stage(input int i, input logic [REG_AW-1:0] dst, input logic wen,
                           input logic rdy, input logic [DATA_W-1:0] data);
    stage_dst[i*REG_AW +: REG_AW]  = dst;
    stage_wen[i]                   = wen;
    stage_ready[i]                 = rdy;
    stage_data[i*DATA_W +: DATA_W] = data;
  endtask

  task automatic clear_stages();
    stage_dst = '0; stage_wen = '0; stage_ready = '0; stage_data = '0;
  endtask

  // Advance one clock; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stall(input string tag, input logic s, input logic [1:0] c);
    check({tag, ".id_stall"}, id_stall, s);
    check({tag, ".if_stall"}, if_stall, s);
    check({tag, ".ex_flush"}, ex_flush, s);
    check({tag, ".hz_cause"}, hz_cause, c);
  endtask

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_hilo = 1'b0; rs = '0; rt = '0; muldiv_start = 1'b0; stall_cnt_clr = 1'b0;
    clear_stages();
    tick(); tick();
    check("rst.busy", muldiv_busy, 1'b0);
    check("rst.cnt", stall_cnt, 4'd0);
    check_stall("rst", 1'b0, 2'b00);
    rst = 1'b0;
    tick();

    // 1: youngest match wins
    set_stage(0, 5'd5, 1'b1, 1'b1, 32'hAAAA0000);
    set_stage(1, 5'd5, 1'b1, 1'b1, 32'h11110000);
    id_rs = 5'd5; id_rs_used = 1'b1; rs = 32'hFFFF_FFFF;
    #1;
    check("t1.rs_fwd", rfRs_forwarding, 32'hAAAA0000);
    check_stall("t1", 1'b0, 2'b00);
    stage_wen[0] = 1'b0;
    #1;
    check("t1.rs_fwd_older", rfRs_forwarding, 32'h11110000);

    // 2: index 0 and no-match pass-through
    clear_stages();
    set_stage(0, 5'd0, 1'b1, 1'b1, 32'hDEAD);
    id_rt = 5'd0; id_rt_used = 1'b1; rt = 32'h0;
    id_rs = 5'd8; rs = 32'h1234;
    #1;
    check("t2.rt_zero", rfRt_forwarding, 32'h0);
    check("t2.rs_pass", rfRs_forwarding, 32'h1234);
    check_stall("t2", 1'b0, 2'b00);
    rt = 32'h77;
    #1;
    check("t2.rt_zero_rf", rfRt_forwarding, 32'h77);
    id_rt_used = 1'b0;

    // 3: load-use
    clear_stages();
    set_stage(0, 5'd9, 1'b1, 1'b0, 32'hBAD);
    set_stage(1, 5'd9, 1'b1, 1'b1, 32'h55);
    id_rs = 5'd9; id_rs_used = 1'b1;
    #1;
    check_stall("t3.lu", 1'b1, 2'b01);
    check("t3.lu_fwd", rfRs_forwarding, 32'hBAD);
    tick();
    check("t3.cnt1", stall_cnt, 4'd1);
    set_stage(0, 5'd0, 1'b0, 1'b0, 32'h0);
    #1;
    check_stall("t3.resolved", 1'b0, 2'b00);
    check("t3.fwd55", rfRs_forwarding, 32'h55);
    set_stage(0, 5'd9, 1'b1, 1'b0, 32'hBAD);
    id_rs_used = 1'b0;
    #1;
    check_stall("t3.unused", 1'b0, 2'b00);
    id_rs = 5'd0; id_rt = 5'd9; id_rt_used = 1'b1;
    #1;
    check_stall("t3.rt_lu", 1'b1, 2'b01);
    check("t3.rt_fwd", rfRt_forwarding, 32'hBAD);
    id_rt_used = 1'b0; clear_stages();
    stall_cnt_clr = 1'b1;
    tick();
    stall_cnt_clr = 1'b0;
    check("t3.clr", stall_cnt, 4'd0);

    // 4: mul/div busy window, start at t, second start at t+2 ignored
    id_hilo = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      muldiv_start = (k == 0 || k == 2);
      if (k == 3) begin
        set_stage(0, 5'd3, 1'b1, 1'b0, 32'h0);
        id_rs = 5'd3; id_rs_used = 1'b1;
      end else begin
        clear_stages(); id_rs_used = 1'b0;
      end
      #1;
      check($sformatf("t4.busy%0d", k), muldiv_busy, (k >= 1 && k <= 4));
      check_stall($sformatf("t4.c%0d", k), (k >= 1 && k <= 4),
                  (k == 3) ? 2'b11 : ((k >= 1 && k <= 4) ? 2'b10 : 2'b00));
      tick();
    end
    muldiv_start = 1'b0;
    clear_stages(); id_rs_used = 1'b0;
    check("t4.cnt", stall_cnt, 4'd4);

    // 5: reset aborts countdown
    muldiv_start = 1'b1;
    tick();
    muldiv_start = 1'b0;
    #1;
    check("t5.busy1", muldiv_busy, 1'b1);
    tick();
    check("t5.busy2", muldiv_busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t5.busy3", muldiv_busy, 1'b0);
    check("t5.cnt", stall_cnt, 4'd0);
    check_stall("t5", 1'b0, 2'b00);
    tick();
    check("t5.busy4", muldiv_busy, 1'b0);
    id_hilo = 1'b0;

    // 6: saturation and clear during stall
    set_stage(0, 5'd7, 1'b1, 1'b0, 32'h0);
    id_rs = 5'd7; id_rs_used = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check("t6.sat", stall_cnt, 4'd15);
    stall_cnt_clr = 1'b1;
    tick();
    check("t6.clr", stall_cnt, 4'd0);
    stall_cnt_clr = 1'b0;
    tick();
    check("t6.inc", stall_cnt, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Parametrised successor to the pipeline's forwarding/load-use unit.
- Resolves ID-stage rs/rt operands against N younger-to-older in-flight stages with per-stage "result ready" flags. Generalises the fixed EX/MEM pair with lw-only stall to any stage count and any late-result instruction.
- Adds a sequential multiply/divide busy counter that stalls HI/LO consumers, plus a saturating stall-cycle performance counter.
- Sits beside the ID stage. It drives IF/ID stall, the EX bubble and the operand-bypass muxes.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register index width; index 0 is hardwired zero.
- FWD_STAGES, 3, number of forwarding sources; stage 0 is youngest (EX), stage FWD_STAGES-1 is oldest (WB).
- MULDIV_LAT, 32, cycles HI/LO stay unavailable after an accepted mul/div start (≥1).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_rs  in  REG_AW  rs index of instruction in ID.
- id_rt  in  REG_AW  rt index of instruction in ID.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_used  in  1  ID instruction reads rt.
- id_hilo  in  1  ID instruction reads HI/LO or starts mul/div.
- rs  in  DATA_W  register-file rs value.
- rt  in  DATA_W  register-file rt value.
- stage_dst  in  FWD_STAGES*REG_AW  destination index per stage; slice i = stage i.
- stage_wen  in  FWD_STAGES  stage i will write stage_dst[i].
- stage_ready  in  FWD_STAGES  stage i's stage_data is final (0 for a load still in EX/MEM).
- stage_data  in  FWD_STAGES*DATA_W  forwardable result per stage.
- muldiv_start  in  1  mul/div in EX this cycle.
- stall_cnt_clr  in  1  clear performance counter.
- if_stall  out  1  hold PC.
- id_stall  out  1  hold IF/ID register.
- ex_flush  out  1  insert bubble into ID/EX.
- rfRs_forwarding  out  DATA_W  resolved rs operand.
- rfRt_forwarding  out  DATA_W  resolved rt operand.
- hz_cause  out  2  00 none, 01 data not ready, 10 mul/div busy, 11 both.
- muldiv_busy  out  1  busy counter non-zero.
- stall_cnt  out  CNT_W  cycles with id_stall=1.

Behaviour:
- Match for operand X (rs or rt): stage i matches when stage_wen[i] && stage_dst[i]==id_X && id_X!=0.
- Forwarding is combinational. The lowest-index matching stage supplies its data; with no match, the register-file value passes through. Index 0 always yields the register-file value. Forwarding does not depend on id_X_used.
- Data-not-ready for operand X: id_X_used && a match exists && the lowest-index match has stage_ready=0. An older ready match does NOT clear the hazard.
- Busy counter mb_cnt (width clog2(MULDIV_LAT+1)):
  - Reset value 0.
  - muldiv_start while mb_cnt==0 loads MULDIV_LAT.
  - Otherwise a non-zero mb_cnt decrements by 1 each cycle.
  - muldiv_start while mb_cnt!=0 is ignored; the counter keeps decrementing.
- muldiv_busy = (mb_cnt!=0). It is combinational from the register, so it rises the cycle after an accepted start.
- Busy hazard = id_hilo && muldiv_busy.
- hz_cause bit0 = data-not-ready on rs or rt; bit1 = busy hazard.
- id_stall = |hz_cause. if_stall and ex_flush equal id_stall in the same cycle.
- stall_cnt:
  - rst or stall_cnt_clr sets it to 0; clear wins over increment.
  - Otherwise it increments when id_stall=1 and saturates at all-ones with no wrap.
- Reset values: mb_cnt=0, stall_cnt=0, muldiv_busy=0. Combinational outputs follow inputs immediately.
- Reset mid-operation aborts the busy countdown; the next cycle sees muldiv_busy=0.
- Simultaneous busy and data hazards report hz_cause=11; the stall is a single stall, not additive.
- Total latency for forwarding and stall outputs is 0 cycles. The only registered state is mb_cnt and stall_cnt.

Test Plan:
1. Stage0 dst=5 wen ready data=0xAAAA0000, stage1 dst=5 data=0x11110000, id_rs=5 → rfRs_forwarding=0xAAAA0000, id_stall=0.
2. id_rt=0, stage0 dst=0 wen data=0xDEAD, rt=0 → rfRt_forwarding=0, no stall. id_rs=8 with no match, rs=0x1234 → 0x1234.
3. Load-use: stage0 dst=9 wen ready=0, id_rs=9 used → id_stall=if_stall=ex_flush=1, hz_cause=01. Next cycle stage0 empty, stage1 dst=9 ready data=0x55 → stall clears, forward 0x55. Same case with id_rs_used=0 → no stall.
4. MULDIV_LAT=4: pulse muldiv_start at cycle t → muldiv_busy high t+1..t+4. id_hilo=1 stalls those cycles, released at t+5. A second start at t+2 is ignored.
5. Assert rst at t+2 of scenario 4 → muldiv_busy=0 from t+3, stall_cnt=0.
6. CNT_W=4, hold a stall 20 cycles → stall_cnt sticks at 15. stall_cnt_clr together with an active stall → stall_cnt=0.
